frog_game_ctrl: RTL
===================

FROG_GAME_CTRL -- requirements
Module: frog_game_ctrl

Interface
REQ-001 SHALL have parameter: clk_freq, 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter: STEP_CYCLES, clk_freq/4, clock cycles per lane scroll step (minimum 2).
REQ-003 SHALL have port: Clk_System  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port: lowRst_System  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports: up_tick, down_tick, left_tick, right_tick  input  1 each  one-cycle debounced move pulses.
REQ-006 SHALL have ports: fila0..fila7  output  8 each  row bitmaps for the matrix image stage; bit c = column c lit.
REQ-007 SHALL have port: lives  output  2  remaining lives.
REQ-008 SHALL have ports: win, game_over  output  1 each  status flags.

Function
REQ-009 SHALL use a 4-state FSM: PLAY, HIT, OVER, WIN.
REQ-010 SHALL hold frog position as frog_row (0..7) and frog_col (0..7); start position is row 7, col 3; row 0 is the goal.
REQ-011 SHALL hold six lane registers, one per row 1..6; rows 0 and 7 never contain cars.
REQ-012 SHALL run a step counter 0..STEP_CYCLES-1 in PLAY and HIT, wrapping to 0; step pulse when counter = STEP_CYCLES-1; counter frozen in OVER and WIN.
REQ-013 SHALL, on step pulse, rotate odd lanes (1,3,5) left ({x[6:0],x[7]}) and even lanes (2,4,6) right ({x[0],x[7:1]}).
REQ-014 SHALL treat a move as valid only when exactly one tick input is high; two or more simultaneous ticks are ignored.
REQ-015 SHALL, in PLAY on a valid tick, update position at the next edge: up row-1, down row+1, left col+1, right col-1, each saturating at 0/7 (no wrap).
REQ-016 SHALL detect collision combinationally in PLAY when frog_row is 1..6 and lane[frog_row][frog_col] = 1.
REQ-017 SHALL give collision priority over a same-cycle move: move is discarded.
REQ-018 SHALL, on collision with lives > 1: decrement lives, move frog to start, enter HIT.
REQ-019 SHALL, on collision with lives = 1: set lives to 0, enter OVER.
REQ-020 SHALL stay in HIT until the next step pulse, then return to PLAY; ticks ignored in HIT; frog not drawn in HIT.
REQ-021 SHALL enter WIN on the edge after frog_row becomes 0 in PLAY; frog and lanes frozen.
REQ-022 SHALL apply a step pulse and a valid move in the same cycle together; collision is evaluated on the resulting state next cycle.
REQ-023 SHALL, in OVER or WIN, perform a full reinitialisation (identical to reset values) on the edge after any valid tick.
REQ-024 SHALL drive filaN = lane[N] OR (frog bit at frog_col if frog_row = N and state is PLAY or WIN); fila0 and fila7 show only the frog.
REQ-025 SHALL drive all fila outputs to 8'hFF in OVER.
REQ-026 SHALL derive fila outputs combinationally from registered state; no added latency.
REQ-027 SHALL assert win only in WIN and game_over only in OVER.

Reset
REQ-028 SHALL on lowRst_System low, immediately: state PLAY, frog row 7 col 3, lives 3, step counter 0, win 0, game_over 0.
REQ-029 SHALL load lanes on reset: 1 = 8'hC0, 2 = 8'h18, 3 = 8'h81, 4 = 8'h30, 5 = 8'h44, 6 = 8'h0C.
REQ-030 SHALL abort any state (HIT, OVER, WIN, mid-count) on reset with no residual effect.

Verification (bench STEP_CYCLES = 4)
REQ-031 SHALL cover: release reset, no ticks -> fila7 = 8'h08, fila1 = 8'hC0, fila2 = 8'h18; after 4 cycles fila1 = 8'h81, fila2 = 8'h0C.
REQ-032 SHALL cover: left_tick ×5 from reset -> col saturates at 7, fila7 = 8'h80; right_tick and left_tick same cycle -> no change.
REQ-033 SHALL cover: up_tick into row 6 with lane6 bit 3 = 1 -> next cycle HIT, lives = 2, frog absent; after step pulse PLAY, fila7 = 8'h08.
REQ-034 SHALL cover: three collisions -> lives 0, game_over = 1, all fila = 8'hFF; one down_tick -> reset values restored, lives = 3.
REQ-035 SHALL cover: collision-free path to row 0 (lanes forced via timed ticks) -> win = 1, fila0 = frog bit, lanes frozen across 8 cycles.
REQ-036 SHALL cover: lowRst_System low during HIT and WIN -> outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/frog_game_ctrl.sv
// Frog game controller: frog position, six scrolling car lanes, lives and game
// status, rendered as eight 8-bit row bitmaps for the matrix image stage.
//
// Parameters
//   clk_freq     system clock frequency in Hz
//   STEP_CYCLES  clock cycles per lane scroll step (minimum 2)
// Ports
//   Clk_System     system clock, all state changes on its rising edge
//   lowRst_System  asynchronous active-low reset
//   up_tick, down_tick, left_tick, right_tick  one-cycle debounced move pulses
//   fila0..fila7   row bitmaps, bit c = column c lit
//   lives          remaining lives
//   win, game_over status flags
module frog_game_ctrl #(
  parameter int unsigned clk_freq    = 50000000,
  parameter int unsigned STEP_CYCLES = clk_freq / 4
) (
  input  logic       Clk_System,
  input  logic       lowRst_System,
  input  logic       up_tick,
  input  logic       down_tick,
  input  logic       left_tick,
  input  logic       right_tick,
  output logic [7:0] fila0,
  output logic [7:0] fila1,
  output logic [7:0] fila2,
  output logic [7:0] fila3,
  output logic [7:0] fila4,
  output logic [7:0] fila5,
  output logic [7:0] fila6,
  output logic [7:0] fila7,
  output logic [1:0] lives,
  output logic       win,
  output logic       game_over
);

  localparam int unsigned CntW = $clog2(STEP_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_CYCLES - 1);

  localparam logic [1:0] StPlay = 2'd0;
  localparam logic [1:0] StHit  = 2'd1;
  localparam logic [1:0] StOver = 2'd2;
  localparam logic [1:0] StWin  = 2'd3;

  localparam logic [2:0] StartRow = 3'd7;
  localparam logic [2:0] StartCol = 3'd3;
  localparam logic [1:0] StartLives = 2'd3;

  // Element N is the lane shown on row N.
  localparam logic [6:1][7:0] LaneInit = {8'h0C, 8'h44, 8'h30, 8'h81, 8'h18, 8'hC0};

  logic [1:0]       state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [1:0]       lives_q, lives_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [6:1][7:0]  lane_q, lane_d;

  logic             running;
  logic             step_pulse;
  logic             move_valid;
  logic             collision;
  logic [7:0][7:0]  lane_full;
  logic [7:0][7:0]  rows_out;
  logic [7:0]       frog_bits;
  logic             show_frog;

  // Rows 0 and 7 are car-free, so padding with zeros makes the collision and
  // render lookups uniform over all eight rows.
  assign lane_full  = {8'h00, lane_q, 8'h00};
  assign running    = (state_q == StPlay) || (state_q == StHit);
  assign step_pulse = running && (cnt_q == CntMax);
  assign move_valid = $onehot({up_tick, down_tick, left_tick, right_tick});
  assign collision  = (state_q == StPlay) && lane_full[row_q][col_q];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;

    if (running) begin
      cnt_d = step_pulse ? '0 : cnt_q + CntW'(1);
    end

    // Odd lanes scroll toward higher columns, even lanes toward lower ones.
    if (step_pulse) begin
      lane_d[1] = {lane_q[1][6:0], lane_q[1][7]};
      lane_d[3] = {lane_q[3][6:0], lane_q[3][7]};
      lane_d[5] = {lane_q[5][6:0], lane_q[5][7]};
      lane_d[2] = {lane_q[2][0], lane_q[2][7:1]};
      lane_d[4] = {lane_q[4][0], lane_q[4][7:1]};
      lane_d[6] = {lane_q[6][0], lane_q[6][7:1]};
    end

    unique case (state_q)
      StPlay: begin
        if (collision) begin
          // A same-cycle move is dropped; the hit wins.
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            row_d   = StartRow;
            col_d   = StartCol;
            state_d = StHit;
          end else begin
            lives_d = 2'd0;
            state_d = StOver;
          end
        end else if (row_q == 3'd0) begin
          state_d = StWin;
        end else if (move_valid) begin
          if (up_tick)    row_d = (row_q == 3'd0) ? 3'd0 : row_q - 3'd1;
          if (down_tick)  row_d = (row_q == 3'd7) ? 3'd7 : row_q + 3'd1;
          if (left_tick)  col_d = (col_q == 3'd7) ? 3'd7 : col_q + 3'd1;
          if (right_tick) col_d = (col_q == 3'd0) ? 3'd0 : col_q - 3'd1;
        end
      end
      StHit: begin
        if (step_pulse) state_d = StPlay;
      end
      StOver, StWin: begin
        // Any single tick restarts the game from the power-on picture.
        if (move_valid) begin
          state_d = StPlay;
          row_d   = StartRow;
          col_d   = StartCol;
          lives_d = StartLives;
          cnt_d   = '0;
          lane_d  = LaneInit;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge Clk_System or negedge lowRst_System) begin
    if (!lowRst_System) begin
      state_q <= StPlay;
      row_q   <= StartRow;
      col_q   <= StartCol;
      lives_q <= StartLives;
      cnt_q   <= '0;
      lane_q  <= LaneInit;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  assign frog_bits = 8'h01 << col_q;
  assign show_frog = (state_q == StPlay) || (state_q == StWin);

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      if (state_q == StOver) begin
        rows_out[n] = 8'hFF;
      end else begin
        rows_out[n] = lane_full[n] | ((show_frog && (row_q == 3'(n))) ? frog_bits : 8'h00);
      end
    end
  end

  assign fila0     = rows_out[0];
  assign fila1     = rows_out[1];
  assign fila2     = rows_out[2];
  assign fila3     = rows_out[3];
  assign fila4     = rows_out[4];
  assign fila5     = rows_out[5];
  assign fila6     = rows_out[6];
  assign fila7     = rows_out[7];
  assign lives     = lives_q;
  assign win       = (state_q == StWin);
  assign game_over = (state_q == StOver);

endmodule
